// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits MSB first, even parity.
// Rebuilt words are queued in a small FIFO with a valid/ready output port.
module sipo_frame_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             par_err,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic             busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic             accept;
  logic [WIDTH:0]   push_word;
  logic [WIDTH:0]   head_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    push       = 1'b0;
    // Word stored as {parity error, data}; error when total ones is odd.
    push_word  = {(^shift_q) ^ serial_in, shift_q};

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {shift_q[WIDTH-2:0], serial_in};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          push    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    pop    = data_valid && data_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    accept = push && ((count_q < (AW+1)'(DEPTH)) || pop);

    if (accept) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = push && !accept;

    if (clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      shift_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head_word  = mem_q[rd_ptr_q];
  assign data_valid = (count_q != '0);
  assign data_out   = data_valid ? head_word[WIDTH-1:0] : '0;
  assign par_err    = data_valid ? head_word[WIDTH] : 1'b0;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel frame receiver downstream of the 4-bit PISO shift stage. It samples a framed serial bit stream (start bit, WIDTH data bits MSB first, even-parity bit) and rebuilds the parallel words. Finished words go into a small output FIFO with a valid/ready handshake for the consuming logic. Parity errors are tagged per word, and words lost to a full FIFO are flagged.

## Interface
- WIDTH, 4, data bits per frame (≥2); matches the PISO word width
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- serial_in  input  1  serial line, MSB-first data
- bit_en  input  1  qualifies serial_in; one bit is consumed per clk with bit_en=1
- clear  input  1  synchronous flush: FSM to IDLE, FIFO emptied, no output pulses
- data_out  output  WIDTH  head-of-FIFO word
- par_err  output  1  parity error tag of head word, valid with data_valid
- data_valid  output  1  FIFO non-empty
- data_ready  input  1  consumer accepts head when data_valid & data_ready
- overflow  output  1  one-cycle pulse when a completed word is dropped
- busy  output  1  FSM not in IDLE

## Operation
- Frame on the line, in bit_en cycles: start bit (1), then WIDTH data bits MSB first, then one parity bit. Even parity: the data bits plus the parity bit hold an even number of 1s.
- When bit_en=0, the line is ignored and state holds.
- FSM states:
  - IDLE: on bit_en & serial_in=1, go to DATA with bit counter = 0. A 0 while idle is line idle and is ignored.
  - DATA: each bit_en cycle, shift_reg <= {shift_reg[WIDTH-2:0], serial_in} and increment the counter. After the WIDTH-th bit, go to PARITY.
  - PARITY: on bit_en, compute err = ^shift_reg ^ serial_in, attempt a push of {err, shift_reg}, and return to IDLE.
- A start bit in the cycle immediately after PARITY is legal, so back-to-back frames need no idle gap.
- FIFO:
  - Push and pop in the same cycle are both performed.
  - A push is accepted when count < DEPTH, or when a pop happens in the same cycle.
  - Otherwise the word is dropped, FIFO contents are unchanged, and overflow pulses for 1 cycle.
  - Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- data_out and par_err come straight from the FIFO head. Their value is don't-care when data_valid=0; the implementation drives 0.
- clear has priority over every other event in the same cycle, including push, pop and start detect.
- Errored words are still delivered, with par_err=1. The consumer decides what to do with them.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, counter = 0, shift_reg = 0, FIFO empty.
  - data_out = 0, par_err = 0, data_valid = 0, overflow = 0, busy = 0.
  - Any partial frame is discarded.
- busy goes high the cycle after the start bit is sampled. It goes low the cycle after the parity bit is sampled.
- Latency: data_valid rises 1 clk after the parity-bit sample edge (FIFO empty case). Minimum frame period is WIDTH+2 bit_en cycles.
- overflow is asserted in the cycle after the dropped push edge, for exactly 1 cycle.
- Pop: head advances on the edge where data_valid & data_ready. data_valid falls the next cycle if that was the last entry.
- data_ready is ignored when data_valid=0.
- Full FIFO, push and pop on the same edge: the new word is accepted, there is no overflow, and count stays at DEPTH.

## Test plan
- WIDTH=4, bit_en=1 continuously. Send start, 1010, parity 0 → data_valid 1 cycle after the parity edge, data_out=4'hA, par_err=0, overflow=0.
- Send start, 0111, parity 0 (odd ones in total) → data_out=4'h7, par_err=1.
- data_ready=0. Send three frames 0x3, 0x5, 0x9, each with correct parity:
  - 0x3 and 0x5 are stored; data_valid stays high.
  - overflow pulses once, one cycle after the third parity edge.
  - With data_ready raised, the consumer pops 0x3 then 0x5, and data_valid falls.
- FIFO full with data_ready=1 held. A fourth frame completes on the same edge as a pop → no overflow, and the new word is delivered in order.
- Gate bit_en to 1 in 3 cycles during the frame for 0xC → same result as the continuous case, and busy stays high for the whole stretched frame.
- Edge cases:
  - Assert reset_n=0 after 2 data bits → all outputs 0 immediately. After release, a full frame 0x6 is received correctly.
  - Assert clear with one word queued and a frame in progress → data_valid=0 next cycle, busy=0.
